// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, buffered long-latency results drain in idle cycles.
// Zero-latency write mux; enqueue over valid/ready, single round-robin grant, full FIFO deasserts ready except for r0 discards.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SOURCES   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter bit HARDWIRE_ZERO = 1'b1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_stall,
    input  logic                              i_pipe_valid,
    input  logic [4:0]                        i_pipe_addr,
    input  logic [DATA_WIDTH-1:0]             i_pipe_data,
    input  logic [NUM_SOURCES-1:0]            i_req_valid,
    input  logic [NUM_SOURCES*5-1:0]          i_req_addr,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_SOURCES-1:0]            o_req_ready,
    output logic                              o_write_enable,
    output logic [4:0]                        o_write_addr,
    output logic [DATA_WIDTH-1:0]             o_write_data,
    output logic [$clog2(FIFO_DEPTH):0]       o_fifo_count,
    output logic [31:0]                       o_busy_mask
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    typedef struct packed {
        logic [4:0]            addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [RW-1:0]         r_rr;

    logic                  w_gnt_any;
    logic [RW-1:0]         w_gnt_idx;
    entry_t                w_gnt_entry;
    logic                  w_full;
    logic                  w_zero_drop;
    logic                  w_hs;
    logic                  w_push;
    logic                  w_pop;

    // Scan from the highest offset down so the first valid source at or after rr wins.
    always_comb begin : grant_search
        int idx;
        idx       = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            idx = (int'(r_rr) + k) % NUM_SOURCES;
            if (i_req_valid[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = RW'(idx);
            end
        end
    end

    assign w_gnt_entry.addr = i_req_addr[int'(w_gnt_idx)*5 +: 5];
    assign w_gnt_entry.data = i_req_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_zero_drop = HARDWIRE_ZERO && (w_gnt_entry.addr == 5'd0);
    assign w_hs        = i_rst_n && w_gnt_any && (!w_full || w_zero_drop);
    assign w_push      = w_hs && !w_zero_drop;
    assign w_pop       = i_rst_n && !i_pipe_valid && !i_stall && (r_count != '0);

    assign o_req_ready  = w_hs ? (NUM_SOURCES'(1) << w_gnt_idx) : '0;
    assign o_fifo_count = r_count;

    always_comb begin
        o_write_enable = 1'b0;
        o_write_addr   = '0;
        o_write_data   = '0;
        if (i_rst_n && i_pipe_valid) begin
            o_write_enable = 1'b1;
            o_write_addr   = i_pipe_addr;
            o_write_data   = i_pipe_data;
        end else if (w_pop) begin
            o_write_enable = 1'b1;
            o_write_addr   = r_mem[r_rptr].addr;
            o_write_data   = r_mem[r_rptr].data;
        end
    end

    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_vld[i]) o_busy_mask[r_mem[i].addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= w_gnt_entry;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rr    <= '0;
        end else begin
            // Push and pop never target the same slot: push needs room, pop needs data.
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_hs) begin
                if (int'(w_gnt_idx) == NUM_SOURCES - 1) r_rr <= '0;
                else                                    r_rr <= w_gnt_idx + 1'b1;
            end
        end
    end

    a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected values are hand-computed constants.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  fifo_count;
    logic [31:0] busy_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int n0, n1;

    regfile_write_arbiter #(
        .DATA_WIDTH(32), .NUM_SOURCES(2), .FIFO_DEPTH(4), .HARDWIRE_ZERO(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_pipe_valid(pipe_valid), .i_pipe_addr(pipe_addr), .i_pipe_data(pipe_data),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_write_enable(we), .o_write_addr(waddr),
        .o_write_data(wdata), .o_fifo_count(fifo_count), .o_busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [4:0] a, input logic [31:0] d);
        req_addr[s*5 +: 5]  = a;
        req_data[s*32 +: 32] = d;
    endtask

    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];

    initial begin
        rst_n = 1'b0; stall = 1'b0; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
        req_valid = 2'b01; req_addr = '0; req_data = '0;
        set_src(0, 5'd3, 32'h1234);
        step; step;
        check("rst_ready", req_ready, 2'b00);
        check("rst_we", we, 1'b0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        #1;
        check("post_rst_count", fifo_count, 3'd0);
        check("post_rst_mask", busy_mask, 32'h0);
        check("post_rst_addr", waddr, 5'd0);
        check("post_rst_data", wdata, 32'h0);
        check("post_rst_we", we, 1'b0);

        // single request
        req_valid = 2'b01; set_src(0, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("single_ready", req_ready, 2'b01);
        step;
        req_valid = 2'b00;
        #1;
        check("single_mask", busy_mask, 32'h20);
        check("single_count", fifo_count, 3'd1);
        check("single_we", we, 1'b1);
        check("single_addr", waddr, 5'd5);
        check("single_data", wdata, 32'hDEAD_BEEF);
        step;
        check("single_drain_count", fifo_count, 3'd0);
        check("single_drain_mask", busy_mask, 32'h0);
        check("single_drain_we", we, 1'b0);

        // pipe priority: rr=1, src0 alone is still granted, then src1
        stall = 1'b1;
        req_valid = 2'b01; set_src(0, 5'd10, 32'hA0);
        #1;
        check("prio_ready0", req_ready, 2'b01);
        step;
        req_valid = 2'b10; set_src(1, 5'd11, 32'hB1);
        #1;
        check("prio_ready1", req_ready, 2'b10);
        step;
        req_valid = 2'b00; stall = 1'b0; pipe_valid = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            pipe_addr = 5'(p); pipe_data = 32'h100 + 32'(p);
            #1;
            check("prio_pipe_addr", waddr, 5'(p));
            check("prio_pipe_data", wdata, 32'h100 + 32'(p));
            check("prio_pipe_count", fifo_count, 3'd2);
            step;
        end
        pipe_valid = 1'b0;
        #1;
        check("prio_mask2", busy_mask, 32'h0000_0C00);
        check("prio_head0_addr", waddr, 5'd10);
        check("prio_head0_data", wdata, 32'hA0);
        step;
        check("prio_head1_addr", waddr, 5'd11);
        check("prio_head1_data", wdata, 32'hB1);
        check("prio_count1", fifo_count, 3'd1);
        check("prio_mask1", busy_mask, 32'h0000_0800);
        step;
        check("prio_empty_we", we, 1'b0);
        check("prio_empty_count", fifo_count, 3'd0);

        // round-robin fill under stall; rr=0 here
        stall = 1'b1; n0 = 0; n1 = 0;
        req_valid = 2'b11;
        set_src(0, 5'd16, 32'h1000); set_src(1, 5'd24, 32'h2000);
        for (int j = 0; j < 4; j++) begin
            #1;
            check("rr_grant", req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
            step;
            if (j % 2 == 0) begin n0++; set_src(0, 5'(16 + n0), 32'h1000 + 32'(n0)); end
            else            begin n1++; set_src(1, 5'(24 + n1), 32'h2000 + 32'(n1)); end
        end
        #1;
        check("full_ready", req_ready, 2'b00);
        check("full_count", fifo_count, 3'd4);
        check("full_mask", busy_mask, 32'h0303_0000);

        // r0 request while full is accepted and dropped
        req_valid = 2'b10; set_src(1, 5'd0, 32'hBAD0);
        #1;
        check("r0_ready", req_ready, 2'b10);
        step;
        req_valid = 2'b00;
        #1;
        check("r0_count", fifo_count, 3'd4);
        check("r0_mask", busy_mask, 32'h0303_0000);

        exp_addr[0] = 5'd16; exp_data[0] = 32'h1000;
        exp_addr[1] = 5'd24; exp_data[1] = 32'h2000;
        exp_addr[2] = 5'd17; exp_data[2] = 32'h1001;
        exp_addr[3] = 5'd25; exp_data[3] = 32'h2001;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_we", we, 1'b1);
            check("drain_addr", waddr, exp_addr[k]);
            check("drain_data", wdata, exp_data[k]);
            step;
        end
        check("drain_done_we", we, 1'b0);
        check("drain_done_count", fifo_count, 3'd0);

        // stall gating; rr=0
        stall = 1'b1;
        req_valid = 2'b11; set_src(0, 5'd7, 32'h77); set_src(1, 5'd8, 32'h88);
        #1;
        check("stall_ready0", req_ready, 2'b01);
        step;
        check("stall_ready1", req_ready, 2'b10);
        step;
        req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_we", we, 1'b0);
            check("stall_addr", waddr, 5'd0);
            check("stall_count", fifo_count, 3'd2);
            step;
        end

        // mid-run reset with three entries; rr=1 before reset
        req_valid = 2'b01; set_src(0, 5'd9, 32'h99);
        step;
        req_valid = 2'b00;
        #1;
        check("prerst_count", fifo_count, 3'd3);
        rst_n = 1'b0; stall = 1'b0;
        req_valid = 2'b11; set_src(0, 5'd12, 32'hC0C0); set_src(1, 5'd13, 32'hD0D0);
        #1;
        check("midrst_we", we, 1'b0);
        check("midrst_ready", req_ready, 2'b00);
        step;
        rst_n = 1'b1;
        #1;
        check("afterrst_count", fifo_count, 3'd0);
        check("afterrst_mask", busy_mask, 32'h0);
        check("afterrst_ready", req_ready, 2'b01);
        check("afterrst_we", we, 1'b0);
        step;
        check("afterrst_count1", fifo_count, 3'd1);
        check("afterrst_mask1", busy_mask, 32'h0000_1000);
        check("afterrst_ready1", req_ready, 2'b10);
        check("afterrst_waddr", waddr, 5'd12);
        check("afterrst_wdata", wdata, 32'hC0C0);
        step;
        req_valid = 2'b00;
        #1;
        check("afterrst_count2", fifo_count, 3'd1);
        check("afterrst_mask2", busy_mask, 32'h0000_2000);
        check("afterrst_waddr2", waddr, 5'd13);
        check("afterrst_wdata2", wdata, 32'hD0D0);
        step;
        check("final_count", fifo_count, 3'd0);
        check("final_mask", busy_mask, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
